conv_frame_sequencer: RTL and testbench

//  Sequences one XS x XS input frame through the conv window pipeline.
//  - Generates raster-order read addresses into the frame buffer.
//  - Drives the pixel valid strobe into the window controller.
//  - Counts window-complete strobes returned by the window controller.
//  - Signals frame completion, abort, or a drain timeout error.

---
 rtl/conv_frame_sequencer_if.sv | 24 ++
 rtl/conv_frame_sequencer.sv | 111 +++++++++++
 tb/tb_conv_frame_sequencer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/conv_frame_sequencer_if.sv
// conv_frame_sequencer_if: control/handshake bundle between layer control, frame buffer and conv datapath
// Ports: iStart/iAbort/iReady/iOutValid flow into the sequencer (slave);
// oRdEn/oRdAddr/oPixValid/oOutCnt/oBusy/oDone/oErr flow out of it.
interface conv_frame_sequencer_if #(parameter int AW = 10);
  logic iStart;
  logic iAbort;
  logic iReady;
  logic iOutValid;
  logic oRdEn;
  logic [AW-1:0] oRdAddr;
  logic oPixValid;
  logic [AW-1:0] oOutCnt;
  logic oBusy;
  logic oDone;
  logic oErr;
  modport slave (
    input iStart, iAbort, iReady, iOutValid,
    output oRdEn, oRdAddr, oPixValid, oOutCnt, oBusy, oDone, oErr
  );
  modport master (
    output iStart, iAbort, iReady, iOutValid,
    input oRdEn, oRdAddr, oPixValid, oOutCnt, oBusy, oDone, oErr
  );
endinterface

// File: rtl/conv_frame_sequencer.sv
// conv_frame_sequencer: streams one XS x XS frame in raster order into the conv window pipeline
// Ports: iCLK clock, iRST async active-high reset, bus (slave) carries start/abort/ready/window
// strobe in and read enable/address, pixel valid, window count, busy/done/error out.
module conv_frame_sequencer #(
  parameter int XS = 32,
  parameter int WS = 5,
  parameter int STRIDE = 1,
  parameter int AW = 10,
  parameter int DRAIN_MAX = 64
) (
  input logic iCLK,
  input logic iRST,
  conv_frame_sequencer_if.slave bus
);
  localparam int NSIDE = (XS - WS) / STRIDE + 1;
  localparam logic [AW-1:0] NOUT = AW'(NSIDE * NSIDE);
  localparam logic [AW-1:0] LAST = AW'(XS * XS - 1);
  localparam int IW = $clog2(DRAIN_MAX + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(DRAIN_MAX - 1);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  state_t state;
  logic [AW-1:0] addr, rdAddr, outCnt, cntNext;
  logic [IW-1:0] idle;
  logic rdEn, pixValid, busy, done, err;
  logic active, cntFull, stray;
  always_comb begin
    active = state == LOAD || state == DRAIN;
    cntFull = outCnt == NOUT;
    // a window strobe outside a frame or beyond the expected count is an error, never counted
    stray = bus.iOutValid && (!active || cntFull);
    cntNext = (active && bus.iOutValid && !cntFull && outCnt != '1) ? outCnt + 1'b1 : outCnt;
  end
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state <= IDLE;
      addr <= '0;
      rdAddr <= '0;
      outCnt <= '0;
      idle <= '0;
      rdEn <= 1'b0;
      pixValid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      pixValid <= rdEn;
      done <= 1'b0;
      if (stray) err <= 1'b1;
      case (state)
        IDLE: begin
          rdEn <= 1'b0;
          if (bus.iStart) begin
            state <= LOAD;
            busy <= 1'b1;
            addr <= '0;
            outCnt <= '0;
            idle <= '0;
            err <= bus.iOutValid;
          end
        end
        LOAD: begin
          if (bus.iAbort) begin
            state <= IDLE;
            busy <= 1'b0;
            rdEn <= 1'b0;
          end else begin
            outCnt <= cntNext;
            idle <= '0;
            rdEn <= bus.iReady;
            if (bus.iReady) begin
              rdAddr <= addr;
              addr <= addr + 1'b1;
              if (addr == LAST) state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          rdEn <= 1'b0;
          if (bus.iAbort) begin
            state <= IDLE;
            busy <= 1'b0;
          end else begin
            outCnt <= cntNext;
            idle <= bus.iOutValid ? '0 : idle + 1'b1;
            if (cntNext == NOUT) begin
              state <= DONE;
              busy <= 1'b0;
              done <= 1'b1;
            end else if (!bus.iOutValid && idle == IDLE_LAST) begin
              state <= DONE;
              busy <= 1'b0;
              done <= 1'b1;
              err <= 1'b1;
            end
          end
        end
        DONE: begin
          rdEn <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
  assign bus.oRdEn = rdEn;
  assign bus.oRdAddr = rdAddr;
  assign bus.oPixValid = pixValid;
  assign bus.oOutCnt = outCnt;
  assign bus.oBusy = busy;
  assign bus.oDone = done;
  assign bus.oErr = err;
endmodule

// File: tb/tb_conv_frame_sequencer.sv
// tb_conv_frame_sequencer: directed self-checking bench for conv_frame_sequencer
module tb_conv_frame_sequencer;
  logic iCLK = 1'b0;
  logic iRST = 1'b1;
  int checks = 0;
  int errors = 0;
  conv_frame_sequencer_if #(.AW(10)) b1 ();
  conv_frame_sequencer_if #(.AW(10)) b2 ();
  conv_frame_sequencer #(.XS(8), .WS(3), .STRIDE(1), .AW(10), .DRAIN_MAX(64)) dut (
    .iCLK(iCLK), .iRST(iRST), .bus(b1.slave)
  );
  conv_frame_sequencer #(.XS(8), .WS(3), .STRIDE(2), .AW(10), .DRAIN_MAX(64)) dut2 (
    .iCLK(iCLK), .iRST(iRST), .bus(b2.slave)
  );
  always #5 iCLK = ~iCLK;
  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic chkZero(input string pfx);
    chk({pfx, "_rdEn"}, 32'(b1.oRdEn), 0);
    chk({pfx, "_rdAddr"}, 32'(b1.oRdAddr), 0);
    chk({pfx, "_pixValid"}, 32'(b1.oPixValid), 0);
    chk({pfx, "_outCnt"}, 32'(b1.oOutCnt), 0);
    chk({pfx, "_busy"}, 32'(b1.oBusy), 0);
    chk({pfx, "_done"}, 32'(b1.oDone), 0);
    chk({pfx, "_err"}, 32'(b1.oErr), 0);
  endtask
  initial begin
    int e;
    int cyc;
    {b1.iStart, b1.iAbort, b1.iReady, b1.iOutValid} = '0;
    {b2.iStart, b2.iAbort, b2.iReady, b2.iOutValid} = '0;
    #12;
    chkZero("reset");
    iRST = 1'b0;
    b1.iStart = 1'b1;
    tick();
    chk("t1_busy", 32'(b1.oBusy), 1);
    chk("t1_rdEn0", 32'(b1.oRdEn), 0);
    b1.iStart = 1'b0;
    b1.iReady = 1'b1;
    for (int k = 0; k < 64; k++) begin
      tick();
      chk("t1_rdEn", 32'(b1.oRdEn), 1);
      chk("t1_rdAddr", 32'(b1.oRdAddr), k);
      chk("t1_pixValid", 32'(b1.oPixValid), int'(k > 0));
    end
    b1.iReady = 1'b0;
    b1.iOutValid = 1'b1;
    for (int j = 1; j <= 36; j++) begin
      tick();
      chk("t1_outCnt", 32'(b1.oOutCnt), j);
      chk("t1_done", 32'(b1.oDone), int'(j == 36));
      if (j == 1) begin
        chk("t1_drainRdEn", 32'(b1.oRdEn), 0);
        chk("t1_lastPix", 32'(b1.oPixValid), 1);
      end
    end
    b1.iOutValid = 1'b0;
    tick();
    chk("t1_donePulse", 32'(b1.oDone), 0);
    chk("t1_outCntHold", 32'(b1.oOutCnt), 36);
    chk("t1_err", 32'(b1.oErr), 0);
    chk("t1_busyEnd", 32'(b1.oBusy), 0);
    b1.iStart = 1'b1;
    tick();
    b1.iStart = 1'b0;
    e = 0;
    cyc = 0;
    while (e < 64 && cyc < 200) begin
      b1.iReady = (cyc % 2) == 0;
      b1.iOutValid = b1.iReady && e == 63;
      tick();
      if (b1.iReady) begin
        chk("t2_rdEn", 32'(b1.oRdEn), 1);
        chk("t2_rdAddr", 32'(b1.oRdAddr), e);
        e++;
      end else chk("t2_noRdEn", 32'(b1.oRdEn), 0);
      cyc++;
    end
    b1.iReady = 1'b0;
    chk("t2_sameCycleCount", 32'(b1.oOutCnt), 1);
    for (int p = 2; p <= 36; p++) begin
      b1.iOutValid = 1'b1;
      tick();
      chk("t2_outCnt", 32'(b1.oOutCnt), p);
      chk("t2_done", 32'(b1.oDone), int'(p == 36));
      b1.iOutValid = 1'b0;
      if (p < 36) begin
        tick();
        chk("t2_gapDone", 32'(b1.oDone), 0);
      end
    end
    tick();
    chk("t2_donePulse", 32'(b1.oDone), 0);
    chk("t2_err", 32'(b1.oErr), 0);
    b1.iStart = 1'b1;
    tick();
    b1.iStart = 1'b0;
    b1.iReady = 1'b1;
    for (int k = 0; k < 64; k++) begin
      b1.iOutValid = k < 30;
      tick();
    end
    chk("t3_loadCnt", 32'(b1.oOutCnt), 30);
    b1.iOutValid = 1'b0;
    b1.iReady = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      tick();
      chk("t3_done", 32'(b1.oDone), int'(i == 64));
      chk("t3_err", 32'(b1.oErr), int'(i == 64));
    end
    chk("t3_outCnt", 32'(b1.oOutCnt), 30);
    tick();
    chk("t3_donePulse", 32'(b1.oDone), 0);
    chk("t3_errSticky", 32'(b1.oErr), 1);
    b1.iStart = 1'b1;
    tick();
    b1.iStart = 1'b0;
    chk("t4_errCleared", 32'(b1.oErr), 0);
    b1.iReady = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      b1.iOutValid = k < 3;
      tick();
      chk("t4_rdAddr", 32'(b1.oRdAddr), k);
    end
    b1.iOutValid = 1'b0;
    b1.iAbort = 1'b1;
    tick();
    b1.iAbort = 1'b0;
    chk("t4_abortRdEn", 32'(b1.oRdEn), 0);
    chk("t4_abortBusy", 32'(b1.oBusy), 0);
    chk("t4_abortDone", 32'(b1.oDone), 0);
    chk("t4_pendingPix", 32'(b1.oPixValid), 1);
    chk("t4_cntHold", 32'(b1.oOutCnt), 3);
    tick();
    chk("t4_idlePix", 32'(b1.oPixValid), 0);
    chk("t4_idleRdEn", 32'(b1.oRdEn), 0);
    chk("t4_idleDone", 32'(b1.oDone), 0);
    b1.iStart = 1'b1;
    tick();
    chk("t4_restartCnt", 32'(b1.oOutCnt), 0);
    chk("t4_restartBusy", 32'(b1.oBusy), 1);
    for (int k = 0; k < 10; k++) begin
      b1.iStart = k == 5;
      tick();
      chk("t6_rdAddr", 32'(b1.oRdAddr), k);
      chk("t6_rdEn", 32'(b1.oRdEn), 1);
    end
    b1.iStart = 1'b0;
    #2 iRST = 1'b1;
    #1 chkZero("t6_async");
    #1 iRST = 1'b0;
    tick();
    chk("t6_idleRdEn", 32'(b1.oRdEn), 0);
    chk("t6_idleBusy", 32'(b1.oBusy), 0);
    chk("t6_idlePix", 32'(b1.oPixValid), 0);
    b1.iReady = 1'b0;
    b2.iStart = 1'b1;
    tick();
    b2.iStart = 1'b0;
    b2.iReady = 1'b1;
    repeat (64) tick();
    b2.iReady = 1'b0;
    b2.iOutValid = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      tick();
      chk("t5_outCnt", 32'(b2.oOutCnt), j);
      chk("t5_done", 32'(b2.oDone), int'(j == 9));
    end
    chk("t5_errBefore", 32'(b2.oErr), 0);
    tick();
    b2.iOutValid = 1'b0;
    chk("t5_extraErr", 32'(b2.oErr), 1);
    chk("t5_cntHold", 32'(b2.oOutCnt), 9);
    chk("t5_donePulse", 32'(b2.oDone), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
